pkt_dist: RTL
=============

PKT_DIST -- requirements
Module: pkt_dist

Interface
REQ-001 SHALL have parameter CNT_W, default 8, meaning the width of each per-port delivered-packet counter.
REQ-002 SHALL have ports: clk  in  1  the single clock; all state on its rising edge.
REQ-003 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: node_i_dist  in  16 / gen_i_dist  in  12 / opr0_i_dist  in  32 / opr1_i_dist  in  32 / mem_wen_i_dist  in  2  incoming packet fields.
REQ-005 SHALL have ports: aeb_i_dist  in  1  destination select, 0 = port A, 1 = port B; sampled only when valid_i_dist=1.
REQ-006 SHALL have ports: valid_i_dist  in  1  incoming packet valid.
REQ-007 SHALL have ports: ready_o_dist  out  1  block can accept the presented packet.
REQ-008 SHALL have ports: node_pkta_o_dist 16, gen_pkta_o_dist 12, opr0_pkta_o_dist 32, opr1_pkta_o_dist 32, mem_wen_pkta_o_dist 2  out  port A packet fields.
REQ-009 SHALL have ports: valid_pkta_o_dist  out  1 / ready_pkta_i_dist  in  1  port A handshake.
REQ-010 SHALL have ports: port B fields and handshake identical to REQ-008/009 with "pktb" in place of "pkta".
REQ-011 SHALL have ports: cnt_pkta_o_dist, cnt_pktb_o_dist  out  CNT_W  packets accepted for A / B.

Function
REQ-012 SHALL hold one packet entry (94 data bits plus a valid flag) per output port, independently.
REQ-013 SHALL drive ready_o_dist = rst_n & (aeb_i_dist ? (~valid_pktb | ready_pktb_i_dist) : (~valid_pkta | ready_pkta_i_dist)), combinationally.
REQ-014 SHALL accept a packet on a rising edge where valid_i_dist=1 and ready_o_dist=1; no other condition accepts.
REQ-015 SHALL, on acceptance, load all five fields into the selected port's entry and set its valid at that edge: 1-cycle latency, no bypass.
REQ-016 SHALL clear a port's valid on an edge where valid=1, ready_pkt*_i_dist=1 and no new packet is accepted for that port.
REQ-017 SHALL, on simultaneous drain and acceptance for the same port, keep valid=1 and present the new packet the next cycle (back-to-back, full throughput).
REQ-018 SHALL hold output fields and valid stable while valid=1 and ready=0 (no overwrite, no drop).
REQ-019 SHALL leave the non-selected port's entry, valid and counter unchanged on every acceptance.
REQ-020 SHALL allow one port to stall while the other keeps accepting: head-of-line blocking only when the presented packet targets the stalled port.
REQ-021 SHALL increment the selected port's counter by 1 on each acceptance, wrapping from 2^CNT_W-1 to 0 with no saturation or flag.
REQ-022 SHALL ignore all packet inputs and aeb_i_dist when valid_i_dist=0.
REQ-023 SHALL keep output field registers unchanged when valid=0 (last value retained; content don't-care to consumers).

Reset
REQ-024 SHALL, while rst_n=0, asynchronously clear both valids, all output field registers and both counters to 0, and force ready_o_dist=0.
REQ-025 SHALL discard buffered packets when reset is asserted mid-operation; no packet is delivered after reset release unless newly accepted.
REQ-026 SHALL accept on the first rising edge after rst_n deasserts if valid_i_dist=1.

Verification
REQ-027 Reset: assert rst_n=0 with valid_i_dist=1 -> ready_o_dist=0, both valids 0, all fields 0, both counters 0.
REQ-028 Single route: node=16'h1234, gen=12'hABC, opr0=32'hDEADBEEF, opr1=32'h0000_0001, mem_wen=2'b10, aeb=1, ready_pktb=1 -> next cycle valid_pktb=1 with the identical fields, valid_pkta=0, cnt_pktb=1; one cycle later valid_pktb=0.
REQ-029 Stall: ready_pkta=0, send two packets to A (aeb=0) -> first held and stable, ready_o_dist=0 for the second; when ready_pkta=1, the first drains and the second loads on the same edge, cnt_pkta=2.
REQ-030 Independent ports: A stalled holding a packet, stream 3 packets to B with ready_pktb=1 -> all three delivered on consecutive cycles, A entry unchanged, cnt_pktb=3.
REQ-031 Counter wrap with CNT_W=8: 256 acceptances to A -> cnt_pkta returns to 0 and cnt_pktb stays 0.
REQ-032 Mid-operation reset: both ports holding packets with ready=0, pulse rst_n low for 1 cycle -> both valids 0 immediately, counters 0, and no stale packet appears after release.

Source files
------------

// File: rtl/pkt_dist.sv
// pkt_dist -- routes incoming packets to one of two output ports.
//
// Each output port holds a single registered packet entry (94 data bits plus
// a valid flag) with a valid/ready handshake toward its consumer. The
// destination is chosen per packet by aeb_i_dist (0 = port A, 1 = port B).
// A packet is accepted when valid_i_dist and ready_o_dist are both high.
// It appears on the selected port one cycle later. A port whose consumer is
// draining on the same edge can take a new packet, so each port can run at
// full throughput.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   node/gen/opr0/opr1/mem_wen_i_dist  incoming packet fields
//   aeb_i_dist                      destination select (0 = A, 1 = B)
//   valid_i_dist / ready_o_dist     input handshake
//   *_pkta_o_dist, valid_pkta_o_dist / ready_pkta_i_dist   port A
//   *_pktb_o_dist, valid_pktb_o_dist / ready_pktb_i_dist   port B
//   cnt_pkta_o_dist, cnt_pktb_o_dist  wrapping per-port accepted-packet counts
module pkt_dist #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      node_i_dist,
    input  logic [11:0]      gen_i_dist,
    input  logic [31:0]      opr0_i_dist,
    input  logic [31:0]      opr1_i_dist,
    input  logic [1:0]       mem_wen_i_dist,
    input  logic             aeb_i_dist,
    input  logic             valid_i_dist,
    output logic             ready_o_dist,
    output logic [15:0]      node_pkta_o_dist,
    output logic [11:0]      gen_pkta_o_dist,
    output logic [31:0]      opr0_pkta_o_dist,
    output logic [31:0]      opr1_pkta_o_dist,
    output logic [1:0]       mem_wen_pkta_o_dist,
    output logic             valid_pkta_o_dist,
    input  logic             ready_pkta_i_dist,
    output logic [15:0]      node_pktb_o_dist,
    output logic [11:0]      gen_pktb_o_dist,
    output logic [31:0]      opr0_pktb_o_dist,
    output logic [31:0]      opr1_pktb_o_dist,
    output logic [1:0]       mem_wen_pktb_o_dist,
    output logic             valid_pktb_o_dist,
    input  logic             ready_pktb_i_dist,
    output logic [CNT_W-1:0] cnt_pkta_o_dist,
    output logic [CNT_W-1:0] cnt_pktb_o_dist
);

    localparam int DATA_W = 94;

    logic [DATA_W-1:0] in_data;
    logic              accept;

    // Per-port views; index 0 is port A, index 1 is port B.
    logic              port_ready [2];
    logic              port_valid [2];
    logic [DATA_W-1:0] port_data  [2];
    logic [CNT_W-1:0]  port_cnt   [2];

    assign in_data = {node_i_dist, gen_i_dist, opr0_i_dist, opr1_i_dist, mem_wen_i_dist};

    assign port_ready[0] = ready_pkta_i_dist;
    assign port_ready[1] = ready_pktb_i_dist;

    // The target port can take a packet if it is empty or is being drained
    // on this edge. Only the targeted port matters. A stalled port therefore
    // blocks only the packets addressed to it.
    assign ready_o_dist = rst_n & (aeb_i_dist ? (~port_valid[1] | port_ready[1])
                                              : (~port_valid[0] | port_ready[0]));
    assign accept       = valid_i_dist & ready_o_dist;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            localparam logic PORT_SEL = (gi == 1);

            logic              load;
            logic              valid_reg, valid_next;
            logic [DATA_W-1:0] data_reg,  data_next;
            logic [CNT_W-1:0]  cnt_reg,   cnt_next;

            assign load = accept & (aeb_i_dist == PORT_SEL);

            // A load takes priority over a drain. On a simultaneous drain
            // and load the entry stays valid and now holds the new packet.
            // Field registers are left untouched when the entry empties.
            always_comb begin
                valid_next = valid_reg;
                data_next  = data_reg;
                cnt_next   = cnt_reg;
                if (load) begin
                    valid_next = 1'b1;
                    data_next  = in_data;
                    cnt_next   = cnt_reg + CNT_W'(1);
                end else if (valid_reg && port_ready[gi]) begin
                    valid_next = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                    cnt_reg   <= '0;
                end else begin
                    valid_reg <= valid_next;
                    data_reg  <= data_next;
                    cnt_reg   <= cnt_next;
                end
            end

            assign port_valid[gi] = valid_reg;
            assign port_data[gi]  = data_reg;
            assign port_cnt[gi]   = cnt_reg;
        end
    endgenerate

    assign {node_pkta_o_dist, gen_pkta_o_dist, opr0_pkta_o_dist,
            opr1_pkta_o_dist, mem_wen_pkta_o_dist} = port_data[0];
    assign {node_pktb_o_dist, gen_pktb_o_dist, opr0_pktb_o_dist,
            opr1_pktb_o_dist, mem_wen_pktb_o_dist} = port_data[1];

    assign valid_pkta_o_dist = port_valid[0];
    assign valid_pktb_o_dist = port_valid[1];
    assign cnt_pkta_o_dist   = port_cnt[0];
    assign cnt_pktb_o_dist   = port_cnt[1];

endmodule
